// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-FF input synchroniser, mid-bit sampling and a one-cycle valid strobe.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] Half = CntW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CntW-1:0] Last = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitIdle
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sync_q;
    logic              rxs;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    assign rxs = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx_serial};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == Half) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == Last) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxs;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == Last) begin
                    cnt_d   = '0;
                    par_d   = (^shift_q) ^ rxs;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == Last) begin
                    cnt_d   = '0;
                    state_d = rxs ? StIdle : StWaitIdle;
                end
            end
            StWaitIdle: begin
                // Line must go high again before a new start bit is accepted.
                cnt_d = '0;
                if (rxs) state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
        busy_d  = (state_d != StIdle);
        if (state_q == StStop && cnt_q == Last) begin
            if (!rxs) begin
                ferr_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_q) begin
                perr_d = 1'b1;
            end
`endif
            else begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = busy_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames against a byte-level model.
module tb_uart_rx;

    localparam int unsigned CPB = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_serial  (rx_serial),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor, sampled on the falling edge.
    logic [7:0] got_q[$];
    int n_ferr   = 0;
    int n_perr   = 0;
    int n_excl   = 0;
    int busy_cyc = 0;

    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) n_excl++;
        if (rx_busy) busy_cyc++;
    end

    logic [7:0] last_good = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic bit_time(input logic v);
        rx_serial = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^b) ^ par_flip);
`endif
        bit_time(stop);
    endtask

    // Model: a frame is either delivered, a framing error, or (8E1) a parity error.
    task automatic run_frame(input logic [7:0] b, input logic stop, input string tag);
        int  v0 = got_q.size();
        int  f0 = n_ferr;
        int  p0 = n_perr;
        logic bad_par = 1'b0;
`ifdef UART_RX_PARITY_EN
        bad_par = par_flip;
`endif
        send_frame(b, stop);
        #1;
        if (!stop) begin
            check({tag, " ferr"}, n_ferr - f0, 1);
            check({tag, " nvalid"}, got_q.size() - v0, 0);
            check({tag, " data held"}, rx_data, last_good);
        end else if (bad_par) begin
            check({tag, " perr"}, n_perr - p0, 1);
            check({tag, " nvalid"}, got_q.size() - v0, 0);
            check({tag, " data held"}, rx_data, last_good);
        end else begin
            check({tag, " nvalid"}, got_q.size() - v0, 1);
            if (got_q.size() > v0) check({tag, " byte"}, got_q[got_q.size() - 1], b);
            check({tag, " ferr"}, n_ferr - f0, 0);
            check({tag, " rx_data"}, rx_data, b);
            last_good = b;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v0, f0, p0;
        reset     = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset rx_busy", rx_busy, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset parity_err", parity_err, 1'b0);
        reset = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        run_frame(8'h41, 1'b1, "f41");
        check("f41 busy low", rx_busy, 1'b0);

        // Short glitch must be rejected in START.
        v0 = got_q.size(); f0 = n_ferr;
        busy_cyc = 0;
        rx_serial = 1'b0;
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("glitch busy<=6", busy_cyc <= 6, 1'b1);
        check("glitch busy seen", busy_cyc > 0, 1'b1);
        check("glitch nvalid", got_q.size() - v0, 0);
        check("glitch ferr", n_ferr - f0, 0);
        check("glitch idle", rx_busy, 1'b0);

        // Bad stop bit, line held low for three bit times in total.
        run_frame(8'h5A, 1'b0, "f5A");
        bit_time(1'b0);
        bit_time(1'b0);
        check("break busy", rx_busy, 1'b1);
        rx_serial = 1'b1;
        @(negedge clk);
        #1;
        check("break busy after high", rx_busy, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        check("break recovered", rx_busy, 1'b0);
        run_frame(8'h3C, 1'b1, "f3C");

        // Back-to-back frames without idle gap.
        run_frame(8'h55, 1'b1, "b2b55");
        run_frame(8'hAA, 1'b1, "b2bAA");
        if (got_q.size() >= 2) begin
            check("b2b order 0", got_q[got_q.size() - 2], 8'h55);
            check("b2b order 1", got_q[got_q.size() - 1], 8'hAA);
        end

        // Reset in the middle of data bit 4 of 8'hFF.
        v0 = got_q.size(); f0 = n_ferr; p0 = n_perr;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort rx_data", rx_data, 8'h00);
        check("abort rx_valid", rx_valid, 1'b0);
        check("abort rx_busy", rx_busy, 1'b0);
        check("abort frame_err", frame_err, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        last_good = 8'h00;
        repeat (2 * CPB) @(negedge clk);
        #1;
        check("abort nvalid", got_q.size() - v0, 0);
        check("abort nerr", (n_ferr - f0) + (n_perr - p0), 0);
        run_frame(8'h12, 1'b1, "f12");

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
        run_frame(8'h07, 1'b1, "par ok");
        par_flip = 1'b1;
        run_frame(8'h07, 1'b1, "par bad");
        par_flip = 1'b0;
`endif

        // Randomized frames with random gaps and occasional bad stop bits.
        for (int n = 0; n < 16; n++) begin
            logic [7:0] b;
            logic       stop;
            int         gap;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            gap  = $urandom_range(0, 2);
`ifdef UART_RX_PARITY_EN
            par_flip = ($urandom_range(0, 3) == 0);
`endif
            run_frame(b, stop, $sformatf("rnd%0d", n));
            if (!stop && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) bit_time(1'b1);
        end
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif

        check("pulses exclusive", n_excl, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
